// File: rtl/gf_pkg.sv
// Shared types, constants and helpers for the GF(2^M) multiply scheduler.
package gf_pkg;

  // Widest field the generic helpers support.
  localparam int unsigned MaxM = 16;

  // x^3 + x + 1, the default primitive polynomial for GF(8).
  localparam logic [3:0] DefPoly = 4'b1011;

  // Scheduler states.
  typedef logic [1:0] state_t;
  localparam state_t StIdle = 2'd0;
  localparam state_t StMul  = 2'd1;
  localparam state_t StDone = 2'd2;

  // Multiply a field element by x and reduce; only the low m bits of p and poly are used.
  function automatic logic [MaxM-1:0] xtime(input logic [MaxM-1:0] p,
                                            input logic [MaxM-1:0] poly,
                                            input int unsigned     m);
    logic [MaxM-1:0] mask;
    logic [MaxM-1:0] r;
    mask = (MaxM'(1) << m) - MaxM'(1);
    r    = (p << 1) & mask;
    if (((p >> (m - 1)) & MaxM'(1)) != '0) begin
      r = r ^ (poly & mask);
    end
    return r;
  endfunction

endpackage

// File: rtl/gf_mul_step.sv
// One MSB-first iteration of a bit-serial GF(2^M) multiply: p_next = p*x + (b_bit ? a : 0).
module gf_mul_step
  import gf_pkg::*;
#(
  parameter int unsigned M    = 3,
  parameter logic [M:0]  POLY = (M + 1)'(DefPoly)
) (
  input  logic [M-1:0] p_i,
  input  logic [M-1:0] a_i,
  input  logic         b_bit_i,
  output logic [M-1:0] p_next_o
);

  logic [MaxM-1:0] xt;

  // Shift-and-reduce, then conditionally add the multiplicand.
  always_comb begin
    xt       = xtime(MaxM'(p_i), MaxM'(POLY), M);
    p_next_o = xt[M-1:0] ^ (b_bit_i ? a_i : '0);
  end

  // Upper bits of the generic helper result are always zero for this field width.
  if (M < MaxM) begin : g_unused
    logic unused_xt;
    assign unused_xt = ^xt[MaxM-1:M];
  end

endmodule

// File: rtl/gf_mul_sched.sv
// Round-robin scheduler sharing one bit-serial GF(2^M) multiplier between NREQ requesters.
module gf_mul_sched
  import gf_pkg::*;
#(
  parameter int unsigned M    = 3,
  parameter int unsigned NREQ = 2,
  parameter logic [M:0]  POLY = (M + 1)'(DefPoly),
  parameter int unsigned IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*M-1:0] req_a,
  input  logic [NREQ*M-1:0] req_b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [M-1:0]      out_p,
  output logic [IDW-1:0]    out_id,
  output logic              busy
);

  localparam int unsigned KW = (M > 1) ? $clog2(M) : 1;

  state_t         state_q, state_d;
  logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0] id_q, id_d;
  logic [M-1:0]   a_q, a_d;
  logic [M-1:0]   b_q, b_d;
  logic [M-1:0]   p_q, p_d;
  logic [KW-1:0]  k_q, k_d;

  logic           grant_found;
  logic [IDW-1:0] grant_idx;
  logic [IDW-1:0] rr_next;
  logic [M-1:0]   a_sel;
  logic [M-1:0]   b_sel;
  logic [M-1:0]   p_step;

  // Circular priority search starting at the round-robin pointer.
  always_comb begin
    int unsigned     cand;
    logic [NREQ-1:0] shifted;
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = 0;
    shifted     = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      cand    = (32'(rr_ptr_q) + i) % NREQ;
      shifted = req_valid >> cand;
      if (!grant_found && shifted[0]) begin
        grant_found = 1'b1;
        grant_idx   = IDW'(cand);
      end
    end
  end

  // Operand selection for the granted requester and the pointer value after a grant.
  always_comb begin
    a_sel   = M'(req_a >> (32'(grant_idx) * M));
    b_sel   = M'(req_b >> (32'(grant_idx) * M));
    rr_next = IDW'((32'(grant_idx) + 32'd1) % NREQ);
  end

  // One-hot accept, only in IDLE and never while reset is asserted.
  always_comb begin
    req_ready = '0;
    if (rst_n && (state_q == StIdle) && grant_found) begin
      req_ready = NREQ'(1) << grant_idx;
    end
  end

  // b is consumed MSB-first by shifting it left each iteration.
  gf_mul_step #(
    .M    (M),
    .POLY (POLY)
  ) u_step (
    .p_i      (p_q),
    .a_i      (a_q),
    .b_bit_i  (b_q[M-1]),
    .p_next_o (p_step)
  );

  // Next-state and datapath updates.
  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    id_d     = id_q;
    a_d      = a_q;
    b_d      = b_q;
    p_d      = p_q;
    k_d      = k_q;
    unique case (state_q)
      StIdle: begin
        if (grant_found) begin
          a_d      = a_sel;
          b_d      = b_sel;
          id_d     = grant_idx;
          rr_ptr_d = rr_next;
          p_d      = '0;
          k_d      = '0;
          // A zero operand makes the product zero; skip the iterations.
          state_d  = ((a_sel == '0) || (b_sel == '0)) ? StDone : StMul;
        end
      end
      StMul: begin
        p_d = p_step;
        b_d = b_q << 1;
        k_d = k_q + KW'(1);
        if (k_q == KW'(M - 1)) begin
          state_d = StDone;
        end
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      rr_ptr_q <= '0;
      id_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      p_q      <= '0;
      k_q      <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      id_q     <= id_d;
      a_q      <= a_d;
      b_q      <= b_d;
      p_q      <= p_d;
      k_q      <= k_d;
    end
  end

  // Result port is a direct view of the held product and tag.
  always_comb begin
    out_valid = (state_q == StDone);
    out_p     = p_q;
    out_id    = id_q;
    busy      = (state_q != StIdle);
  end

endmodule

// File: tb/tb_gf_mul_sched.sv
// Self-checking bench for gf_mul_sched against a polynomial-arithmetic GF(8) model.
module tb_gf_mul_sched;

  localparam int M       = 3;
  localparam int NREQ    = 2;
  localparam int IDW     = 1;
  localparam int AW      = NREQ * M;
  localparam int PolyInt = 'b1011;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [NREQ-1:0] req_valid = '0;
  logic [NREQ-1:0] req_ready;
  logic [AW-1:0]   req_a = '0;
  logic [AW-1:0]   req_b = '0;
  logic            out_valid;
  logic            out_ready = 1'b1;
  logic [M-1:0]    out_p;
  logic [IDW-1:0]  out_id;
  logic            busy;

  int checks = 0;
  int errors = 0;
  int rr_m   = 0;

  gf_mul_sched #(
    .M    (M),
    .NREQ (NREQ),
    .POLY (4'b1011),
    .IDW  (IDW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_p     (out_p),
    .out_id    (out_id),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Carry-less product, then long division by the field polynomial.
  function automatic int gmul(input int a, input int b);
    int r;
    r = 0;
    for (int i = 0; i < M; i++) if (((b >> i) & 1) != 0) r = r ^ (a << i);
    for (int i = 2 * M - 2; i >= M; i--) if (((r >> i) & 1) != 0) r = r ^ (PolyInt << (i - M));
    return r;
  endfunction

  function automatic int exp_grant(input logic [NREQ-1:0] vm, input int rr);
    for (int i = 0; i < NREQ; i++) begin
      if (((int'(vm) >> ((rr + i) % NREQ)) & 1) != 0) return (rr + i) % NREQ;
    end
    return -1;
  endfunction

  // One complete operation: request, accept, wait for result, optional stall, handshake.
  task automatic op(input logic [NREQ-1:0] vm, input logic [AW-1:0] av, input logic [AW-1:0] bv,
                    input int stall, input string tag);
    int g, ea, eb, ep, lat;
    for (int w = 0; w < 30 && busy; w++) tick();
    chk({tag, ":idle"}, 32'(busy), 0);
    req_valid = vm;
    req_a     = av;
    req_b     = bv;
    out_ready = 1'b1;
    #1;
    g  = exp_grant(vm, rr_m);
    ea = (int'(av) >> (g * M)) & ((1 << M) - 1);
    eb = (int'(bv) >> (g * M)) & ((1 << M) - 1);
    ep = gmul(ea, eb);
    chk({tag, ":ready"}, 32'(req_ready), 32'(1 << g));
    tick();
    rr_m      = (g + 1) % NREQ;
    out_ready = (stall == 0);
    lat = 1;
    while (!out_valid && lat < 20) begin
      chk({tag, ":busy_ready"}, {30'd0, busy, req_ready == '0}, 32'd3);
      tick();
      lat++;
    end
    chk({tag, ":latency"}, 32'(lat), (ea == 0 || eb == 0) ? 32'd1 : 32'(M + 1));
    chk({tag, ":p"}, 32'(out_p), 32'(ep));
    chk({tag, ":id"}, 32'(out_id), 32'(g));
    for (int s = 0; s < stall; s++) begin
      chk({tag, ":stall_ready"}, 32'(req_ready), 0);
      tick();
      chk({tag, ":stall_valid"}, 32'(out_valid), 1);
      chk({tag, ":stall_p"}, 32'(out_p), 32'(ep));
      chk({tag, ":stall_id"}, 32'(out_id), 32'(g));
    end
    req_valid = '0;
    out_ready = 1'b1;
    tick();
    chk({tag, ":drained"}, {31'd0, out_valid | busy}, 0);
  endtask

  initial begin
    logic [AW-1:0]   av, bv;
    logic [NREQ-1:0] vm;
    int              r;

    // Reset with both requesters pending.
    rst_n     = 1'b0;
    req_valid = 2'b11;
    tick();
    tick();
    chk("rst_ready", 32'(req_ready), 0);
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_p", 32'(out_p), 0);
    chk("rst_id", 32'(out_id), 0);
    rst_n = 1'b1;
    rr_m  = 0;

    // Directed multiplies and zero shortcuts.
    op(2'b11, {3'd1, 3'd3}, {3'd1, 3'd5}, 0, "mul_3x5");
    op(2'b10, {3'd6, 3'd0}, {3'd0, 3'd0}, 0, "zero_b");
    op(2'b01, {3'd0, 3'd7}, {3'd0, 3'd7}, 0, "mul_7x7");
    op(2'b01, {3'd0, 3'd2}, {3'd0, 3'd4}, 0, "mul_2x4");
    op(2'b10, {3'd0, 3'd0}, {3'd5, 3'd0}, 0, "zero_a");

    // Both requesters continuously valid: grants must alternate.
    op(2'b11, {3'd4, 3'd3}, {3'd6, 3'd5}, 0, "rr0");
    op(2'b11, {3'd4, 3'd3}, {3'd6, 3'd5}, 0, "rr1");
    op(2'b11, {3'd7, 3'd2}, {3'd3, 3'd6}, 0, "rr2");
    op(2'b11, {3'd7, 3'd2}, {3'd3, 3'd6}, 0, "rr3");

    // Back-pressure held for 5 cycles.
    op(2'b11, {3'd5, 3'd6}, {3'd7, 3'd3}, 5, "bp");

    // Reset during the second MUL cycle discards the operation.
    req_valid = 2'b01;
    req_a     = {3'd0, 3'd5};
    req_b     = {3'd0, 3'd6};
    out_ready = 1'b1;
    #1;
    chk("mr_accept", 32'(req_ready), 32'(1 << exp_grant(2'b01, rr_m)));
    tick();
    req_valid = '0;
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    rr_m  = 0;
    for (int i = 0; i < 6; i++) begin
      chk("mr_quiet", {30'd0, out_valid, busy}, 0);
      tick();
    end
    op(2'b11, {3'd3, 3'd1}, {3'd2, 3'd1}, 0, "mr_after");

    // Exhaustive GF(8) sweep through randomly chosen requester slots.
    for (int a = 0; a < 8; a++) begin
      for (int b = 0; b < 8; b++) begin
        r  = $urandom_range(0, NREQ - 1);
        av = AW'($urandom);
        bv = AW'($urandom);
        av[r*M +: M] = M'(a);
        bv[r*M +: M] = M'(b);
        vm = NREQ'(1 << r);
        op(vm, av, bv, 0, "sweep");
      end
    end

    // Random traffic with random back-pressure.
    for (int n = 0; n < 30; n++) begin
      vm = NREQ'($urandom_range(1, 3));
      av = AW'($urandom);
      bv = AW'($urandom);
      op(vm, av, bv, int'($urandom_range(0, 3)), "rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
